// File: rtl/pipe_stall_controller.sv
// Pipeline stall/flush controller: stage-register enables, bubble insertion and a
// RUN / DMEM_WAIT / MD_BUSY sequencer. Define STALL_PERF_CNT_EN for perf counters.
module pipe_stall_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             LoadUseHaz,
    input  logic             BranchTaken,
    input  logic             IMemReady,
    input  logic             DMemReq,
    input  logic             DMemReady,
    input  logic             MulDivStart,
    input  logic             MulDivDone,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IDEXWrite,
    output logic             EXMEMWrite,
    output logic             MEMWBWrite,
    output logic             IFIDFlush,
    output logic             IDEXFlush,
    output logic             EXMEMFlush,
    output logic [1:0]       State,
    output logic             PendRedirect,
    output logic [CNT_W-1:0] StallCycles,
    output logic [CNT_W-1:0] FlushCount
);

    localparam logic [1:0] ST_RUN       = 2'd0;
    localparam logic [1:0] ST_DMEM_WAIT = 2'd1;
    localparam logic [1:0] ST_MD_BUSY   = 2'd2;

    // Enable vectors are {PC, IFID, IDEX, EXMEM, MEMWB}; flush vectors are {IFID, IDEX, EXMEM}.
    localparam logic [4:0] WR_ALL     = 5'b11111;
    localparam logic [4:0] WR_NONE    = 5'b00000;
    localparam logic [4:0] WR_MD      = 5'b00011;
    localparam logic [4:0] WR_LOADUSE = 5'b00111;
    localparam logic [4:0] WR_FETCH   = 5'b01111;
    localparam logic [2:0] FL_NONE    = 3'b000;
    localparam logic [2:0] FL_IFID    = 3'b100;
    localparam logic [2:0] FL_IDEX    = 3'b010;
    localparam logic [2:0] FL_EXMEM   = 3'b001;

    logic [1:0] state_reg;
    logic [1:0] state_next;
    logic       pend_reg;
    logic       pend_next;

    logic       mem_rule_en;
    logic       md_rule_en;
    logic [4:0] run_wr;
    logic [2:0] run_fl;
    logic [1:0] run_state;
    logic       run_branch;

    logic [4:0] base_wr;
    logic [2:0] base_fl;
    logic       branch_sel;
    logic [4:0] wr_vec;
    logic [2:0] fl_vec;

    // The state that is being left already covers its own stall rule.
    always_comb begin
        mem_rule_en = (state_reg != ST_DMEM_WAIT);
        md_rule_en  = (state_reg != ST_MD_BUSY);
    end

    always_comb begin
        run_wr     = WR_ALL;
        run_fl     = FL_NONE;
        run_state  = ST_RUN;
        run_branch = 1'b0;
        if (mem_rule_en && DMemReq && !DMemReady) begin
            run_wr    = WR_NONE;
            run_state = ST_DMEM_WAIT;
        end else if (md_rule_en && MulDivStart) begin
            run_wr    = WR_MD;
            run_fl    = FL_EXMEM;
            run_state = ST_MD_BUSY;
        end else if (BranchTaken) begin
            run_fl     = FL_IFID;
            run_branch = 1'b1;
        end else if (LoadUseHaz) begin
            run_wr = WR_LOADUSE;
            run_fl = FL_IDEX;
        end else if (!IMemReady || pend_reg) begin
            run_wr = WR_FETCH;
            run_fl = FL_IFID;
        end
    end

    // Hold states freeze the pipe until their completion strobe arrives.
    always_comb begin
        base_wr    = run_wr;
        base_fl    = run_fl;
        state_next = run_state;
        branch_sel = run_branch;
        case (state_reg)
            ST_DMEM_WAIT: begin
                if (!DMemReady) begin
                    base_wr    = WR_NONE;
                    base_fl    = FL_NONE;
                    state_next = ST_DMEM_WAIT;
                    branch_sel = 1'b0;
                end
            end
            ST_MD_BUSY: begin
                if (!MulDivDone) begin
                    base_wr    = WR_MD;
                    base_fl    = FL_EXMEM;
                    state_next = ST_MD_BUSY;
                    branch_sel = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

    // An outstanding redirect fetch keeps the PC frozen and squashes whatever IF/ID latches.
    always_comb begin
        wr_vec = base_wr;
        fl_vec = base_fl;
        if (pend_reg) begin
            wr_vec[4] = 1'b0;
            fl_vec[2] = base_fl[2] | base_wr[3];
        end
    end

    always_comb begin
        pend_next = pend_reg;
        if (branch_sel && !IMemReady) begin
            pend_next = 1'b1;
        end else if (IMemReady && wr_vec[3]) begin
            pend_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_RUN;
            pend_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            pend_reg  <= pend_next;
        end
    end

    assign PCWrite      = wr_vec[4];
    assign IFIDWrite    = wr_vec[3];
    assign IDEXWrite    = wr_vec[2];
    assign EXMEMWrite   = wr_vec[1];
    assign MEMWBWrite   = wr_vec[0];
    assign IFIDFlush    = fl_vec[2];
    assign IDEXFlush    = fl_vec[1];
    assign EXMEMFlush   = fl_vec[0];
    assign State        = state_reg;
    assign PendRedirect = pend_reg;

`ifdef STALL_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_val [2];

    assign cnt_inc = {|fl_vec, ~wr_vec[4]};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;
            // Saturating: stops at all-ones instead of wrapping.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else if (cnt_inc[gi] && !(&cnt_reg)) begin
                    cnt_reg <= cnt_reg + CNT_ONE;
                end
            end
            assign cnt_val[gi] = cnt_reg;
        end
    endgenerate

    assign StallCycles = cnt_val[0];
    assign FlushCount  = cnt_val[1];
`else
    assign StallCycles = '0;
    assign FlushCount  = '0;
`endif

endmodule

// File: doc/pipe_stall_controller.md
PIPE_STALL_CONTROLLER -- requirements
Module: pipe_stall_controller

Interface
REQ-001 Parameter CNT_W, default 32, width of each performance counter.
REQ-002 clk  input  1  single clock for all state; rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 LoadUseHaz  input  1  load-use stall request from hazard detection.
REQ-005 BranchTaken  input  1  branch/jump resolved taken in ID (PCSrc).
REQ-006 IMemReady  input  1  instruction fetch completes this cycle.
REQ-007 DMemReq / DMemReady  input  1 / 1  MEM-stage access present / completes this cycle.
REQ-008 MulDivStart / MulDivDone  input  1 / 1  multicycle EX op begins / result valid this cycle.
REQ-009 PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, MEMWBWrite  output  1 each  stage register enables.
REQ-010 IFIDFlush, IDEXFlush, EXMEMFlush  output  1 each  insert bubble into the named register.
REQ-011 State  output  2  current FSM state: RUN=0, DMEM_WAIT=1, MD_BUSY=2.
REQ-012 PendRedirect  output  1  taken-branch fetch outstanding.
REQ-013 StallCycles, FlushCount  output  CNT_W each  performance counters.

Function
REQ-014 Control outputs SHALL be combinational from registered state plus current inputs (zero-cycle latency); State/PendRedirect/counters are registered.
REQ-015 "RUN evaluation", applied in priority order: (a) DMemReq && !DMemReady: all five Write=0, no flush, next DMEM_WAIT; (b) MulDivStart: PCWrite=IFIDWrite=IDEXWrite=0, EXMEMWrite=MEMWBWrite=1, EXMEMFlush=1, next MD_BUSY; (c) BranchTaken: all Write=1, IFIDFlush=1; (d) LoadUseHaz: PCWrite=IFIDWrite=0, IDEXFlush=1, rest Write=1; (e) !IMemReady or PendRedirect: PCWrite=0, IFIDFlush=1, rest Write=1; (f) otherwise all Write=1, no flush.
REQ-016 RUN SHALL apply RUN evaluation; next state RUN unless (a)/(b) selects otherwise.
REQ-017 DMEM_WAIT with DMemReady=0 SHALL hold all Write=0 and no flush; with DMemReady=1 SHALL apply RUN evaluation treating (a) false.
REQ-018 MD_BUSY with MulDivDone=0 SHALL repeat REQ-015(b) outputs and ignore BranchTaken, LoadUseHaz, IMemReady; with MulDivDone=1 SHALL apply RUN evaluation treating (b) false.
REQ-019 DMemReq && !DMemReady during MD_BUSY SHALL NOT occur (EX blocked); behaviour is don't-care.
REQ-020 PendRedirect SHALL set when (c) is taken with IMemReady=0, and clear on a cycle with IMemReady=1 and IFIDWrite=1; set has priority if both.
REQ-021 While PendRedirect=1, IFIDFlush SHALL be 1 whenever IFIDWrite=1 and PCWrite SHALL be 0, in every state.
REQ-022 At most one of {Write=0, Flush=1} per register per cycle; flush implies that register's Write=1.

Reset
REQ-023 rst_n low SHALL immediately force State=RUN, PendRedirect=0, counters=0, independent of clk.
REQ-024 During reset, outputs SHALL equal RUN evaluation with PendRedirect=0; reset mid-DMEM_WAIT or mid-MD_BUSY abandons the operation with no residual stall.

Configuration
REQ-025 Macro STALL_PERF_CNT_EN SHALL compile in counters: StallCycles += 1 each cycle PCWrite=0; FlushCount += 1 each cycle any Flush=1; both saturate at all-ones.
REQ-026 Without STALL_PERF_CNT_EN, StallCycles and FlushCount SHALL be constant 0 and no counter flops SHALL exist; ports remain.

Verification
REQ-027 RUN, DMemReq=1, DMemReady=0 for 3 cycles then 1 -> Write all 0 for 3 cycles, State=1, then all 1, State=0.
REQ-028 MulDivStart=1, MulDivDone after 4 cycles -> 4 cycles EXMEMFlush=1, PCWrite=0, State=2; 5th cycle all Write=1, State=0; BranchTaken pulsed mid-op ignored.
REQ-029 BranchTaken=1 with IMemReady=0, IMemReady=1 two cycles later -> IFIDFlush=1 three cycles, PendRedirect=1 two cycles then 0.
REQ-030 LoadUseHaz=1 and BranchTaken=1 same cycle -> branch wins: IFIDFlush=1, IDEXFlush=0, PCWrite=1.
REQ-031 rst_n low mid-MD_BUSY, StallCycles=7 -> State=0, PendRedirect=0, counters 0 without clock edge.
REQ-032 STALL_PERF_CNT_EN, CNT_W=4, 20 DMEM stall cycles -> StallCycles saturates at 15.
